dot_product_tree: RTL and testbench
===================================

# dot_product_tree

Parametrised, pipelined N-tap multiply-accumulate engine with valid/ready handshakes and multi-beat frame accumulation. Each accepted beat presents NUM_TAPS data/coefficient pairs. Products are summed through a registered binary adder tree, and the tree sums are accumulated across the beats of a frame. The block replaces the fixed two-level MAC/adder hierarchy in the filter datapath and sits between the sample buffer and the result sink.

## Interface

Parameters:

- DATA_WIDTH, 8, width of each data element
- COEFF_WIDTH, 8, width of each coefficient
- NUM_TAPS, 4, pairs per beat; power of two, ≥2
- ACC_BITS, 8, accumulator guard bits beyond the tree sum
- Derived: LOG_TAPS = $clog2(NUM_TAPS); RES_WIDTH = DATA_WIDTH+COEFF_WIDTH+LOG_TAPS+ACC_BITS

Ports:

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_last  in  1  final beat of frame
- data  in  NUM_TAPS*DATA_WIDTH  tap i at [i*DATA_WIDTH +: DATA_WIDTH]
- coeff  in  NUM_TAPS*COEFF_WIDTH  tap i at [i*COEFF_WIDTH +: COEFF_WIDTH]
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid & out_ready
- result  out  RES_WIDTH  frame sum
- overflow  out  1  frame sum exceeded RES_WIDTH; qualified by out_valid

## Operation

- **Stage M:** registers NUM_TAPS products, each DATA_WIDTH+COEFF_WIDTH bits.
- **Stages T1..T_LOG_TAPS:** each stage is a registered pairwise adder level and grows the width by 1 bit per level.
- **Stage A:** accumulator.
  - A valid tree sum on the first beat of a frame (acc_empty=1) loads acc ← sum.
  - Otherwise acc ← acc + sum, modulo 2^RES_WIDTH.
  - The overflow sticky flag is set on carry-out (unsigned) or sign overflow (signed), and is cleared on the frame's first beat.
- **Last beat at A:** result ← acc_next, overflow ← sticky_next, out_valid ← 1, acc_empty ← 1.
- **Frame length:** a single-beat frame (in_last on its first beat) gives result = that tree sum. There is no frame length limit; overflow reports lost range.
- **Bubbles:** beats with in_valid=0 or in_ready=0 carry an invalid marker down the pipe. The accumulator ignores invalid markers, and frames may contain bubbles.
- **Marker propagation:** valid and last markers travel with the data through every stage.
- **Arithmetic:** unsigned by default; see Configuration.

## Timing

- **Stall:** stall = out_valid & ~out_ready. in_ready = ~stall, combinational.
  - While stalled, every pipeline register, the accumulator and the output registers hold.
- **Output handshake:** out_valid, result and overflow stay stable until the handshake completes.
- **Latency:** from acceptance of a last beat to out_valid = LOG_TAPS+2 cycles, with no stall. For NUM_TAPS=4 this is 4 cycles.
- **Throughput:** one beat per cycle. A back-to-back result handshake with a new result in the same cycle is allowed; out_valid stays 1 and result updates.
- **Output clear:** the out_ready handshake with no new result arriving clears out_valid the next edge.
- **Reset values:** in_ready=1 after reset deassert; out_valid=0, result=0, overflow=0. Pipeline markers are cleared, acc=0, acc_empty=1, sticky=0.
- **Reset mid-frame:** the partial frame is discarded and no result is emitted. The next accepted beat starts a new frame.

## Configuration

- DOTP_SIGNED_EN
  - **Defined:** data and coeff are two's complement. Products and tree sums are sign-extended, result is signed, and overflow means signed-range overflow.
  - **Undefined:** all operands are unsigned, zero-extended, and overflow means carry out of RES_WIDTH.

## Test plan

Defaults apply unless stated: NUM_TAPS=4, 8-bit operands, RES_WIDTH=26.

- **Single beat:** data all 1, coeff {1,2,3,4}, in_last=1, out_ready=1 → result=10 and overflow=0 exactly 4 cycles after acceptance.
- **Multi-beat with bubble:** 3-beat frame of the same vectors, with in_valid low for 2 cycles between beats 1 and 2 → one result=30; no output for beats 1-2.
- **Backpressure:** hold out_ready=0 with a result pending and keep in_valid=1.
  - Required: in_ready=0, and result/out_valid stable for 5 cycles.
  - On release: a queued second frame (result 10) appears with no loss or duplication.
- **Overflow (unsigned):** 259-beat frame of all-255 operands → result=257036, overflow=1. The 258-beat frame gives 67105800, overflow=0.
- **Reset mid-frame:** assert reset after 2 beats of a 3-beat frame, then send a 1-beat frame (sum 10) → only result=10 is emitted. Outputs are 0 during reset.
- **Signed (DOTP_SIGNED_EN):** all data=-1, coeff=3 → result=-12. All data=-128, coeff=-128 → result=65536, overflow=0.

Source files
------------

// File: rtl/dot_product_tree_if.sv
// Beat-input / frame-result handshake bundle for dot_product_tree.
// The master drives beats and consumes results; the slave is the engine.
interface dot_product_tree_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS    = 4,
  parameter int ACC_BITS    = 8
);
  localparam int LOG_TAPS  = $clog2(NUM_TAPS);
  localparam int RES_WIDTH = DATA_WIDTH + COEFF_WIDTH + LOG_TAPS + ACC_BITS;

  logic                            in_valid;
  logic                            in_ready;
  logic                            in_last;
  logic [NUM_TAPS*DATA_WIDTH-1:0]  data;
  logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff;
  logic                            out_valid;
  logic                            out_ready;
  logic [RES_WIDTH-1:0]            result;
  logic                            overflow;

  modport master (
    output in_valid, in_last, data, coeff, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, in_last, data, coeff, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/dot_product_tree.sv
// Pipelined NUM_TAPS-way multiply / registered adder tree with multi-beat frame accumulation.
// Define DOTP_SIGNED_EN for two's-complement operands and signed-range overflow.
module dot_product_tree #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS    = 4,
  parameter int ACC_BITS    = 8
) (
  input logic               clk,
  input logic               reset,
  dot_product_tree_if.slave dp
);
  localparam int LOG_TAPS   = $clog2(NUM_TAPS);
  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
  localparam int TREE_WIDTH = PROD_WIDTH + LOG_TAPS;
  localparam int RES_WIDTH  = TREE_WIDTH + ACC_BITS;
`ifdef DOTP_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic                           stall_s;
  logic                           accept_s;
  logic [NUM_TAPS*PROD_WIDTH-1:0] prod_s;
  logic [NUM_TAPS*PROD_WIDTH-1:0] prod_r;
  logic                           m_valid_r;
  logic                           m_last_r;

  logic [TREE_WIDTH-1:0]          tree_sum_s;
  logic                           tree_valid_s;
  logic                           tree_last_s;
  logic [RES_WIDTH-1:0]           sum_ext_s;
  logic [RES_WIDTH:0]             add_s;
  logic                           ovf_s;
  logic [RES_WIDTH-1:0]           acc_next_s;
  logic                           sticky_next_s;
  logic [RES_WIDTH-1:0]           acc_r;
  logic                           acc_empty_r;
  logic                           sticky_r;

  logic                           out_valid_r;
  logic [RES_WIDTH-1:0]           result_r;
  logic                           overflow_r;

  // A pending result that is not being taken freezes the whole pipe.
  assign stall_s      = out_valid_r & ~dp.out_ready;
  assign accept_s     = dp.in_valid & ~stall_s;
  assign dp.in_ready  = ~stall_s;
  assign dp.out_valid = out_valid_r;
  assign dp.result    = result_r;
  assign dp.overflow  = overflow_r;

  // Per-tap products; operands are extended to the product width so the low bits are exact in either mode.
  always_comb begin
    prod_s = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      prod_s[i*PROD_WIDTH +: PROD_WIDTH] =
        {{COEFF_WIDTH{SIGNED_EN & dp.data[i*DATA_WIDTH + DATA_WIDTH - 1]}},
         dp.data[i*DATA_WIDTH +: DATA_WIDTH]} *
        {{DATA_WIDTH{SIGNED_EN & dp.coeff[i*COEFF_WIDTH + COEFF_WIDTH - 1]}},
         dp.coeff[i*COEFF_WIDTH +: COEFF_WIDTH]};
    end
  end

  // Stage M: product registers with their beat markers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_r    <= '0;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else if (!stall_s) begin
      prod_r    <= prod_s;
      m_valid_r <= accept_s;
      m_last_r  <= accept_s & dp.in_last;
    end
  end

  for (genvar l = 0; l < LOG_TAPS; l++) begin : g_lvl
    localparam int IN_W  = PROD_WIDTH + l;
    localparam int OUT_N = NUM_TAPS >> (l + 1);

    logic [2*OUT_N*IN_W-1:0]    src_s;
    logic                       src_valid_s;
    logic                       src_last_s;
    logic [OUT_N*(IN_W+1)-1:0]  sum_s;
    logic [OUT_N*(IN_W+1)-1:0]  sum_r;
    logic                       valid_r;
    logic                       last_r;

    if (l == 0) begin : g_first
      assign src_s       = prod_r;
      assign src_valid_s = m_valid_r;
      assign src_last_s  = m_last_r;
    end else begin : g_next
      assign src_s       = g_lvl[l-1].sum_r;
      assign src_valid_s = g_lvl[l-1].valid_r;
      assign src_last_s  = g_lvl[l-1].last_r;
    end

    // Pairwise adders, one bit wider than their operands.
    always_comb begin
      sum_s = '0;
      for (int j = 0; j < OUT_N; j++) begin
        sum_s[j*(IN_W+1) +: IN_W+1] =
          {SIGNED_EN & src_s[(2*j+1)*IN_W - 1], src_s[2*j*IN_W +: IN_W]} +
          {SIGNED_EN & src_s[(2*j+2)*IN_W - 1], src_s[(2*j+1)*IN_W +: IN_W]};
      end
    end

    // Tree level register; markers ride along with the partial sums.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sum_r   <= '0;
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end else if (!stall_s) begin
        sum_r   <= sum_s;
        valid_r <= src_valid_s;
        last_r  <= src_valid_s & src_last_s;
      end
    end
  end

  assign tree_sum_s   = g_lvl[LOG_TAPS-1].sum_r;
  assign tree_valid_s = g_lvl[LOG_TAPS-1].valid_r;
  assign tree_last_s  = g_lvl[LOG_TAPS-1].last_r;
  assign sum_ext_s    = {{ACC_BITS{SIGNED_EN & tree_sum_s[TREE_WIDTH-1]}}, tree_sum_s};
  assign add_s        = {1'b0, acc_r} + {1'b0, sum_ext_s};

`ifdef DOTP_SIGNED_EN
  // Same-sign operands producing an opposite-sign sum leave the signed range.
  assign ovf_s = (acc_r[RES_WIDTH-1] == sum_ext_s[RES_WIDTH-1]) &
                 (add_s[RES_WIDTH-1] != acc_r[RES_WIDTH-1]);
`else
  assign ovf_s = add_s[RES_WIDTH];
`endif

  // Next accumulator value: first beat of a frame loads, later beats add and may set the sticky flag.
  always_comb begin
    acc_next_s    = '0;
    sticky_next_s = 1'b0;
    if (acc_empty_r) begin
      acc_next_s    = sum_ext_s;
      sticky_next_s = 1'b0;
    end else begin
      acc_next_s    = add_s[RES_WIDTH-1:0];
      sticky_next_s = sticky_r | ovf_s;
    end
  end

  // Stage A: frame accumulator; invalid markers leave it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r       <= '0;
      acc_empty_r <= 1'b1;
      sticky_r    <= 1'b0;
    end else if (!stall_s && tree_valid_s) begin
      acc_r       <= acc_next_s;
      acc_empty_r <= tree_last_s;
      sticky_r    <= sticky_next_s;
    end
  end

  // Result registers: loaded on a frame's last beat, otherwise dropped once handed over.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      overflow_r  <= 1'b0;
    end else if (!stall_s) begin
      if (tree_valid_s && tree_last_s) begin
        out_valid_r <= 1'b1;
        result_r    <= acc_next_s;
        overflow_r  <= sticky_next_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dot_product_tree.sv
// Self-checking bench for dot_product_tree: table-driven frames with a result scoreboard,
// plus latency, backpressure, overflow and reset-mid-frame sequences.
module tb_dot_product_tree;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int NT = 4;
  localparam int AB = 8;
  localparam int RW = 26;
  localparam int NV = 6;

  typedef struct {
    logic [RW-1:0] res;
    logic          ovf;
  } exp_t;

  typedef struct {
    logic [NT*DW-1:0] data;
    logic [NT*CW-1:0] coeff;
    int               beats;
    int               gap;
    logic [RW-1:0]    res;
    logic             ovf;
  } vec_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  vec_t vecs[NV];
  int   checks;
  int   errors;

  dot_product_tree_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT), .ACC_BITS(AB)) dp ();

  dot_product_tree #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT), .ACC_BITS(AB)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard on every result handshake.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (dp.out_valid && dp.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0d required=none", dp.result);
        end else begin
          e = exp_q.pop_front();
          chk("result", longint'(dp.result), longint'(e.res));
          chk("overflow", longint'(dp.overflow), longint'(e.ovf));
        end
      end
    end
  endtask

  task automatic wait_accept();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      done = dp.in_ready;
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
  endtask

  task automatic send_beat(input logic [NT*DW-1:0] d, input logic [NT*CW-1:0] c, input logic last);
    dp.in_valid = 1'b1;
    dp.data     = d;
    dp.coeff    = c;
    dp.in_last  = last;
    wait_accept();
    dp.in_valid = 1'b0;
    dp.in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [NT*DW-1:0] d, input logic [NT*CW-1:0] c,
                            input int beats, input int gap, input logic [RW-1:0] res, input logic ovf);
    exp_t e;
    e.res = res;
    e.ovf = ovf;
    exp_q.push_back(e);
    for (int b = 0; b < beats; b++) begin
      send_beat(d, c, b == beats - 1);
      if (b == 0) repeat (gap) tick();
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && !dp.out_valid) break;
      tick();
    end
    chk("drain_pending", longint'(exp_q.size()), 64'sd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    clk          = 1'b0;
    reset        = 1'b0;
    dp.in_valid  = 1'b0;
    dp.in_last   = 1'b0;
    dp.data      = '0;
    dp.coeff     = '0;
    dp.out_ready = 1'b1;
    checks       = 0;
    errors       = 0;

`ifdef DOTP_SIGNED_EN
    vecs[0] = '{32'hFFFFFFFF, 32'h03030303, 1, 0, RW'(-12), 1'b0};
    vecs[1] = '{32'h80808080, 32'h80808080, 1, 0, 26'd65536, 1'b0};
    vecs[2] = '{32'h01010101, 32'h04030201, 3, 2, 26'd30, 1'b0};
    vecs[3] = '{32'h04030201, 32'h08070605, 1, 0, 26'd70, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'h04030201, 2, 0, RW'(-20), 1'b0};
    vecs[5] = '{32'h7F7F7F7F, 32'h81818181, 1, 0, RW'(-64516), 1'b0};
`else
    vecs[0] = '{32'h01010101, 32'h04030201, 1, 0, 26'd10, 1'b0};
    vecs[1] = '{32'h01010101, 32'h04030201, 3, 2, 26'd30, 1'b0};
    vecs[2] = '{32'h04030201, 32'h08070605, 1, 0, 26'd70, 1'b0};
    vecs[3] = '{32'h281E140A, 32'h01000000, 1, 0, 26'd40, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2, 0, 26'd520200, 1'b0};
    vecs[5] = '{32'h00000000, 32'hFFFFFFFF, 1, 0, 26'd0, 1'b0};
`endif

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", longint'(dp.out_valid), 64'sd0);
    chk("rst_result", longint'(dp.result), 64'sd0);
    chk("rst_overflow", longint'(dp.overflow), 64'sd0);
    #2 reset = 1'b1;
    tick();
    chk("rst_in_ready", longint'(dp.in_ready), 64'sd1);

    // Table frames, back to back
    for (int i = 0; i < NV; i++) begin
      send_frame(vecs[i].data, vecs[i].coeff, vecs[i].beats, vecs[i].gap, vecs[i].res, vecs[i].ovf);
    end
    wait_drain();

    // Latency of a single-beat frame, counted in edges including the accepting one
    send_frame(32'h01010101, 32'h04030201, 1, 0, 26'd10, 1'b0);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      if (dp.out_valid) lat = k;
      else tick();
    end
    chk("latency", longint'(lat), 64'sd4);
    chk("latency_result", longint'(dp.result), 64'sd10);
    wait_drain();

    // Backpressure: result held, next beat waits with in_valid high
    dp.out_ready = 1'b0;
    send_frame(32'h04030201, 32'h08070605, 1, 0, 26'd70, 1'b0);
    for (int k = 0; k < 20 && !dp.out_valid; k++) tick();
    chk("bp_pending", longint'(dp.out_valid), 64'sd1);
    exp_q.push_back('{26'd10, 1'b0});
    dp.in_valid = 1'b1;
    dp.data     = 32'h01010101;
    dp.coeff    = 32'h04030201;
    dp.in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", longint'(dp.in_ready), 64'sd0);
      chk("bp_out_valid", longint'(dp.out_valid), 64'sd1);
      chk("bp_result", longint'(dp.result), 64'sd70);
      tick();
    end
    dp.out_ready = 1'b1;
    wait_accept();
    dp.in_valid = 1'b0;
    dp.in_last  = 1'b0;
    wait_drain();

    // Long frames around the top of the result range
`ifdef DOTP_SIGNED_EN
    send_frame(32'h80808080, 32'h80808080, 512, 0, 26'h2000000, 1'b1);
    send_frame(32'h80808080, 32'h80808080, 511, 0, 26'd33488896, 1'b0);
`else
    send_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 259, 0, 26'd257036, 1'b1);
    send_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 258, 0, 26'd67105800, 1'b0);
`endif
    wait_drain();

    // Reset in the middle of a frame: partial frame vanishes
    send_beat(32'h01010101, 32'h04030201, 1'b0);
    send_beat(32'h01010101, 32'h04030201, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", longint'(dp.out_valid), 64'sd0);
    chk("mid_rst_result", longint'(dp.result), 64'sd0);
    chk("mid_rst_overflow", longint'(dp.overflow), 64'sd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    send_frame(32'h01010101, 32'h04030201, 1, 0, 26'd10, 1'b0);
    wait_drain();
    repeat (10) tick();
    chk("final_out_valid", longint'(dp.out_valid), 64'sd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
